// File: rtl/dbus_ctrl_if.sv
// External data-bus signal bundle: req/ack handshake with address, lane select and data.
// The controller drives the master side; the memory or peripheral slave drives ack/rdata.
interface dbus_ctrl_if #(
    parameter int ADDR_W = 32
) ();
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        sel;
    logic [31:0]       wdata;
    logic              ack;
    logic [31:0]       rdata;

    modport master (
        output req,
        output we,
        output addr,
        output sel,
        output wdata,
        input  ack,
        input  rdata
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  sel,
        input  wdata,
        output ack,
        output rdata
    );
endinterface

// File: rtl/dbus_ctrl.sv
// Data-bus controller behind the MEM stage: turns single-cycle requests into req/ack bus cycles.
// Optional one-entry posted-write buffer enabled by defining DBUS_POSTED_WRITE_EN.
//
// state | meaning
// IDLE  | no bus cycle; stall_req_o follows cpu_ce_i; a request starts a bus cycle
// BUSY  | bus cycle active, pipeline stalled, waiting for ack or timeout
// DONE  | access finished, read data presented, held while stall_i is high
// WPOST | posted store running in the background (DBUS_POSTED_WRITE_EN only)
module dbus_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_ce_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [3:0]        cpu_sel_i,
    input  logic [31:0]       cpu_wdata_i,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic [31:0]       cpu_rdata_o,
    output logic              stall_req_o,
    output logic              bus_err_o,
    dbus_ctrl_if.master       bus
);

`ifdef DBUS_POSTED_WRITE_EN
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_DONE  = 2'd2,
        S_WPOST = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;
`endif

    localparam logic [7:0]        CNT_LAST  = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

    state_t            state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        sel_q, sel_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              drop_q, drop_d;
    logic              timeout;

    assign timeout = (cnt_q == CNT_LAST);

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        sel_d       = sel_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        err_d       = 1'b0;
        cnt_d       = cnt_q;
        drop_d      = drop_q;
        stall_req_o = 1'b0;

        case (state_q)
            S_IDLE: begin
                stall_req_o = cpu_ce_i;
                if (cpu_ce_i && !flush_i) begin
                    req_d   = 1'b1;
                    we_d    = cpu_we_i;
                    addr_d  = cpu_addr_i & WORD_MASK;
                    sel_d   = cpu_sel_i;
                    wdata_d = cpu_wdata_i;
                    cnt_d   = 8'd0;
                    drop_d  = 1'b0;
                    state_d = S_BUSY;
`ifdef DBUS_POSTED_WRITE_EN
                    if (cpu_we_i) begin
                        stall_req_o = 1'b0;
                        state_d     = S_WPOST;
                    end
`endif
                end
            end

            S_BUSY: begin
                stall_req_o = 1'b1;
                if (flush_i) begin
                    drop_d = 1'b1;
                end
                // ack has priority over a coinciding timeout
                if (bus.ack || timeout) begin
                    req_d  = 1'b0;
                    cnt_d  = 8'd0;
                    drop_d = 1'b0;
                    if (drop_q || flush_i) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DONE;
                        if (bus.ack) begin
                            if (!we_q) begin
                                rdata_d = bus.rdata;
                            end
                        end else begin
                            rdata_d = 32'd0;
                            err_d   = 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            S_DONE: begin
                // a request still present here is the one just served; never reissue it
                if (flush_i || !stall_i) begin
                    state_d = S_IDLE;
                end
            end

`ifdef DBUS_POSTED_WRITE_EN
            S_WPOST: begin
                stall_req_o = cpu_ce_i;
                if (bus.ack || timeout) begin
                    req_d   = 1'b0;
                    cnt_d   = 8'd0;
                    err_d   = !bus.ack;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
`endif

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            sel_q   <= 4'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
            cnt_q   <= 8'd0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
        end
    end

    assign bus.req     = req_q;
    assign bus.we      = we_q;
    assign bus.addr    = addr_q;
    assign bus.sel     = sel_q;
    assign bus.wdata   = wdata_q;
    assign cpu_rdata_o = rdata_q;
    assign bus_err_o   = err_q;

endmodule
